frame_timing_ctrl: RTL
======================

Name: frame_timing_ctrl

Overview:
- Frame-level sequencer for the timing generator.
- Holds the active horizontal/vertical timing configuration and drives it to the horizontal pixel generator.
- Gates that generator through gen_enable and counts lines from its end-of-line pulse to produce vertical sync/blank/active and frame_start.
- Accepts new configuration through a valid/ready handshake; a new configuration takes effect only at a frame boundary, so no frame is ever torn.

Parameters:
N, 12, width of every timing field, counter and sum result.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-low.
start  in  1  one-cycle request to begin frame generation.
stop  in  1  one-cycle request to stop at end of current frame.
cfg_valid  in  1  configuration offer.
cfg_ready  out  1  configuration accept; transfer when cfg_valid & cfg_ready.
cfg_h_sync, cfg_h_back, cfg_h_active, cfg_h_front  in  N each  horizontal fields, pixels.
cfg_v_sync, cfg_v_back, cfg_v_active, cfg_v_front  in  N each  vertical fields, lines.
line_end  in  1  pulse from horizontal generator on last pixel of a line.
gen_enable  out  1  enable to horizontal generator.
h_sync_width, h_back_porch, h_active_pix, h_front_porch  out  N each  active horizontal configuration.
v_sync, v_blank, v_active  out  1  vertical region flags.
frame_start  out  1  one-cycle pulse at first line of each frame.
line_cnt  out  N  current line, 0..v_total-1.
busy  out  1  state != IDLE.
cfg_error  out  1  one-cycle pulse: offered configuration rejected.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; all outputs 0 except cfg_ready=1.
  - Active and shadow configuration cleared; cfg_loaded=0; pending=0.
  - Reset mid-frame drops gen_enable immediately.
- Validation on each handshake:
  - Computed in N+2 bits: h_total=sum of 4 h fields; v_total=sum of 4 v fields.
  - Reject if h_sync, h_active, v_sync or v_active is 0, or if either total > 2^N-1.
  - Rejected offer: handshake still completes, data discarded, cfg_error=1 for one cycle, state unchanged.
- Accepted offer:
  - Written to shadow; pending=1; cfg_ready=0 while pending=1.
  - In IDLE, shadow→active on the next cycle: pending=0, cfg_loaded=1, cfg_ready=1.
- States:
  - IDLE: gen_enable=0. start & cfg_loaded → ARM. start without cfg_loaded is ignored.
  - ARM (1 cycle):
    - If pending, shadow→active.
    - line_cnt=0; → RUN.
    - Next cycle: gen_enable=1, frame_start=1.
  - RUN:
    - On line_end: line_cnt+1. At line_cnt==v_total-1: wrap to 0, frame_start=1 next cycle, and if pending, shadow→active in the same cycle as the wrap.
    - stop → DRAIN.
    - start in RUN is ignored.
  - DRAIN:
    - Identical to RUN, except the wrapping line_end goes → IDLE: gen_enable=0, line_cnt=0, frame_start not pulsed.
    - A pending shadow is transferred on that same wrapping line_end.
- Vertical flags (registered from line_cnt, valid while busy; all 0 in IDLE):
  - v_sync for line_cnt < vs.
  - v_active for vs+vb ≤ line_cnt < vs+vb+va.
  - v_blank = busy & !v_active (includes sync and both porches).
- Simultaneous events:
  - stop with the wrapping line_end in RUN: a new frame begins (frame_start pulses), then DRAIN covers that whole frame.
  - stop and start in the same cycle in IDLE: start wins.
  - cfg handshake in the same cycle as a shadow→active transfer: the old shadow transfers and the new one is captured.
  - line_end is ignored in IDLE and ARM.
- h_* outputs change only on a shadow→active transfer.

Test Plan:
- Config vs=2,vb=3,va=10,vf=1, h=4/8/32/4; start → ARM 1 cycle, gen_enable=1, frame_start, line_cnt 0..15 over 16 line_end, v_sync on lines 0-1, v_active on lines 5-14, frame_start again after 16th line_end.
- Offer cfg_v_active=0 → cfg_error pulse 1 cycle, cfg_ready stays 1, h_*/v timing unchanged; offer with v_total=4096 at N=12 → cfg_error.
- Mid-frame (line_cnt=7) offer va=20 → cfg_ready=0 until the wrap; h_*/vertical change exactly on the wrapping line_end; first new frame has 26 lines.
- stop at line_cnt=3 → DRAIN, gen_enable stays 1 until the line_end at line_cnt=15, then IDLE, busy=0, no frame_start pulse.
- start with no config loaded → stays IDLE, busy=0; reset asserted in RUN at line_cnt=9 → gen_enable=0 and all flags 0 immediately, cfg_loaded=0 after release.
- stop coincident with the wrapping line_end → frame_start pulses, one full extra frame of 16 line_end, then IDLE.

Source files
------------

// File: rtl/frame_timing_ctrl.sv
// Frame-level sequencer: holds the active timing configuration, gates the horizontal
// generator and counts lines into vertical sync/blank/active flags and frame_start.
module frame_timing_ctrl #(
    parameter int unsigned N = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N-1:0] cfg_h_sync,
    input  logic [N-1:0] cfg_h_back,
    input  logic [N-1:0] cfg_h_active,
    input  logic [N-1:0] cfg_h_front,
    input  logic [N-1:0] cfg_v_sync,
    input  logic [N-1:0] cfg_v_back,
    input  logic [N-1:0] cfg_v_active,
    input  logic [N-1:0] cfg_v_front,
    input  logic         line_end,
    output logic         gen_enable,
    output logic [N-1:0] h_sync_width,
    output logic [N-1:0] h_back_porch,
    output logic [N-1:0] h_active_pix,
    output logic [N-1:0] h_front_porch,
    output logic         v_sync,
    output logic         v_blank,
    output logic         v_active,
    output logic         frame_start,
    output logic [N-1:0] line_cnt,
    output logic         busy,
    output logic         cfg_error
);

    typedef struct packed {
        logic [N-1:0] hs, hb, ha, hf;
        logic [N-1:0] vs, vb, va, vf;
    } cfg_t;

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDrain} state_e;

    localparam logic [N+1:0] MaxTotal = {2'b00, {N{1'b1}}};

    state_e       state_q, state_d;
    cfg_t         active_q, shadow_q, cfg_in, cfg_d;
    logic         pending_q, pending_d, cfg_loaded_q;
    logic [N+1:0] h_total, v_total;
    logic [N-1:0] act_v_total, line_d, act_start, act_end;
    logic         hs_ok, hs_bad, cfg_ok, eol, wrap, xfer, fs_d, busy_d;

    assign cfg_ready    = ~pending_q;
    assign cfg_in       = '{cfg_h_sync, cfg_h_back, cfg_h_active, cfg_h_front,
                            cfg_v_sync, cfg_v_back, cfg_v_active, cfg_v_front};
    assign h_sync_width  = active_q.hs;
    assign h_back_porch  = active_q.hb;
    assign h_active_pix  = active_q.ha;
    assign h_front_porch = active_q.hf;

    always_comb begin
        h_total = (N+2)'(cfg_h_sync) + (N+2)'(cfg_h_back) + (N+2)'(cfg_h_active)
                + (N+2)'(cfg_h_front);
        v_total = (N+2)'(cfg_v_sync) + (N+2)'(cfg_v_back) + (N+2)'(cfg_v_active)
                + (N+2)'(cfg_v_front);
        cfg_ok  = (cfg_h_sync != '0) && (cfg_h_active != '0) && (cfg_v_sync != '0)
               && (cfg_v_active != '0) && (h_total <= MaxTotal) && (v_total <= MaxTotal);
        hs_ok   = cfg_valid & cfg_ready & cfg_ok;
        hs_bad  = cfg_valid & cfg_ready & ~cfg_ok;

        // Active config was validated on entry, so its total fits in N bits.
        act_v_total = active_q.vs + active_q.vb + active_q.va + active_q.vf;
        wrap        = (line_cnt == act_v_total - N'(1));
        eol         = line_end & ((state_q == StRun) | (state_q == StDrain));

        state_d = state_q;
        line_d  = line_cnt;
        xfer    = 1'b0;
        fs_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                xfer = pending_q;
                if (start && cfg_loaded_q) state_d = StArm;
            end
            StArm: begin
                xfer    = pending_q;
                line_d  = '0;
                fs_d    = 1'b1;
                state_d = StRun;
            end
            StRun, StDrain: begin
                if (state_q == StRun && stop) state_d = StDrain;
                if (eol) begin
                    if (wrap) begin
                        line_d = '0;
                        xfer   = pending_q;
                        if (state_q == StRun) fs_d = 1'b1;
                        else                  state_d = StIdle;
                    end else begin
                        line_d = line_cnt + N'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        cfg_d     = xfer ? shadow_q : active_q;
        pending_d = (pending_q & ~xfer) | hs_ok;
        busy_d    = (state_d != StIdle);
        act_start = cfg_d.vs + cfg_d.vb;
        act_end   = act_start + cfg_d.va;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            cfg_loaded_q <= 1'b0;
            line_cnt     <= '0;
            gen_enable   <= 1'b0;
            frame_start  <= 1'b0;
            busy         <= 1'b0;
            v_sync       <= 1'b0;
            v_active     <= 1'b0;
            v_blank      <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= cfg_d;
            if (hs_ok) shadow_q <= cfg_in;
            pending_q    <= pending_d;
            cfg_loaded_q <= cfg_loaded_q | xfer;
            line_cnt     <= line_d;
            gen_enable   <= (state_d == StRun) || (state_d == StDrain);
            frame_start  <= fs_d;
            busy         <= busy_d;
            // Flags track the next line count and config so they align with line_cnt.
            v_sync       <= busy_d && (line_d < cfg_d.vs);
            v_active     <= busy_d && (line_d >= act_start) && (line_d < act_end);
            v_blank      <= busy_d && !((line_d >= act_start) && (line_d < act_end));
            cfg_error    <= hs_bad;
        end
    end

endmodule
